// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, instruction
// width, default reset PC and the saturating counter helper.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int          INST_W           = 32;
    localparam int          CNT_W            = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pc_fetch_mux2x1.sv
// Two-input multiplexer used as the next-PC select of pc_fetch.
module mux2x1 #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic              slct,
    output logic [DATA_W-1:0] out
);

    assign out = slct ? in_1 : in_0;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: issues word-aligned requests, registers returned words,
// handles stall (HOLD) and redirects that arrive while a request is outstanding
// (DRAIN). Optional accepted-instruction counter under PC_FETCH_PERF_CNT_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       fetch_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pend_q, pend_d;
    logic                vld_q, vld_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   pco_q, pco_d;

    logic [ADDR_W-1:0]   tgt_aligned;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   pc_sel;
    logic [ADDR_W-1:0]   pend_eff;
    logic                accept;

    assign tgt_aligned = branch_target & ~ADDR_W'(3);
    assign pc_inc      = pc_q + ADDR_W'(4);
    assign accept      = (state_q == ST_FETCH) && imem_ack;
    // A redirect arriving on the same cycle as the drain ack still wins.
    assign pend_eff    = branch_taken ? tgt_aligned : pend_q;

    mux2x1 #(.DATA_W(ADDR_W)) u_next_pc (
        .in_0 (pc_inc),
        .in_1 (tgt_aligned),
        .slct (branch_taken),
        .out  (pc_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = stall ? ST_HOLD : ST_FETCH;
                end else if (branch_taken) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = rst_n && (state_q != ST_HOLD);
        imem_addr = pc_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        vld_d     = vld_q;
        inst_d    = inst_q;
        pco_d     = pco_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d = imem_rdata;
                    pco_d  = pc_q;
                    vld_d  = 1'b1;
                    pc_d   = pc_sel;
                end else begin
                    if (branch_taken) begin
                        pend_d = tgt_aligned;
                    end
                    if (!stall) begin
                        vld_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d = pc_sel;
                end
            end
            ST_DRAIN: begin
                // The word returned for the old address is dropped.
                if (imem_ack) begin
                    pc_d  = pend_eff;
                    vld_d = 1'b0;
                end else begin
                    pend_d = pend_eff;
                    if (!stall) begin
                        vld_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
            vld_q  <= 1'b0;
            inst_q <= '0;
            pco_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            vld_q  <= vld_d;
            inst_q <= inst_d;
            pco_q  <= pco_d;
        end
    end

    assign inst_valid = vld_q;
    assign inst_out   = inst_q;
    assign pc_out     = pco_q;

`ifdef PC_FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign fetch_count = cnt_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus pushes expected {inst, pc} pairs, a
// monitor pops one each cycle that inst_valid is presented.
module tb_pc_fetch;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    pc_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, advance one clock, return at the next negedge.
    task automatic step(input logic s, input logic b, input logic [31:0] tgt,
                        input logic a, input logic [31:0] rd);
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        imem_ack      = a;
        imem_rdata    = rd;
        @(negedge clk);
    endtask

    task automatic acc(input logic [31:0] pc, input logic s, input logic b, input logic [31:0] tgt);
        exp_q.push_back('{word_of(pc), pc});
        step(s, b, tgt, 1'b1, word_of(pc));
    endtask

    task automatic hold_exp(input logic [31:0] pc);
        exp_q.push_back('{word_of(pc), pc});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
    endtask

    // Monitor: one pop per cycle in which the DUT presents a valid instruction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && inst_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid: got pc %h inst %h, required inst_valid=0", pc_out, inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_out !== e.inst || pc_out !== e.pc) begin
                        n_bad++;
                        $display("FAIL out_pair: got pc %h inst %h required pc %h inst %h",
                                 pc_out, inst_out, e.pc, e.inst);
                    end
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;

        // Streaming with ack tied high, plus counter after 5 accepts
        do_reset();
        for (int i = 0; i < 5; i++) begin
            acc(32'(i * 4), 1'b0, 1'b0, 32'h0);
            chk("stream_addr", imem_addr, 32'((i + 1) * 4));
        end
        idle();
`ifdef PC_FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd5);
`else
        chk("fetch_count", fetch_count, 32'd0);
`endif

        // Stall after accept of 0x4 holds outputs and drops the request
        do_reset();
        acc(32'h0, 1'b0, 1'b0, 32'h0);
        acc(32'h4, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            hold_exp(32'h4);
            step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
        end
        hold_exp(32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h8);
        acc(32'h8, 1'b0, 1'b0, 32'h0);
        idle();

        // Branch on accept aligns the target; branch while held redirects pc
        do_reset();
        acc(32'h0, 1'b0, 1'b1, 32'h0000_0103);
        chk("br_addr", imem_addr, 32'h100);
        acc(32'h100, 1'b0, 1'b0, 32'h0);
        chk("br_next", imem_addr, 32'h104);
        acc(32'h104, 1'b1, 1'b0, 32'h0);
        hold_exp(32'h104);
        step(1'b1, 1'b1, 32'h0000_0201, 1'b0, 32'h0);
        hold_exp(32'h104);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("hold_br_addr", imem_addr, 32'h200);
        idle();

        // Redirect during a delayed ack: returned word discarded
        do_reset();
        acc(32'h0, 1'b0, 1'b0, 32'h0);
        chk("drain_pre", imem_addr, 32'h4);
        step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_old", imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("drain_wait", imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("drain_tgt", imem_addr, 32'h40);
        acc(32'h40, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0060, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0070, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("last_redirect", imem_addr, 32'h70);
        idle();

        // Reset pulsed mid-request; late ack belongs to RESET_PC
        do_reset();
        acc(32'h0, 1'b0, 1'b0, 32'h0);
        acc(32'h4, 1'b0, 1'b0, 32'h0);
        imem_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_inst", inst_out, 32'd0);
        chk("mid_rst_pc_out", pc_out, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart_addr", imem_addr, 32'h0);
        acc(32'h0, 1'b0, 1'b0, 32'h0);
        chk("restart_next", imem_addr, 32'h4);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
